// File: rtl/window_scan_ctrl.sv
// Frame sequencer for the fifo_segment 3x3 line buffer: forwards raster pixels to the segment,
// tags pixels that complete a legal 3x3 window (stride 1/2) and reports window coordinates.
module window_scan_ctrl #(
  parameter int DATA_W  = 14,
  parameter int DIM_W   = 8,
  parameter int SEG_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DIM_W-1:0]         cfg_width,
  input  logic [DIM_W-1:0]         cfg_height,
  input  logic [1:0]               cfg_stride,
  input  logic signed [DATA_W-1:0] pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic                     win_ready,
  output logic                     seg_rst,
  output logic                     seg_wr_en,
  output logic signed [DATA_W-1:0] seg_pixel,
  input  logic                     seg_data_valid,
  output logic                     win_valid,
  output logic [DIM_W-1:0]         win_row,
  output logic [DIM_W-1:0]         win_col,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     cfg_err
);

  localparam int CNT_W = (SEG_LAT > 1) ? $clog2(SEG_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [DIM_W-1:0]   w_q, w_d, h_q, h_d, ow_q, ow_d;
  logic [DIM_W-1:0]   r_q, r_d, c_q, c_d;
  logic [DIM_W-1:0]   orow_q, orow_d, ocol_q, ocol_d;
  logic               s2_q, s2_d;
  logic [SEG_LAT-1:0] tag_q, tag_d;
  logic [CNT_W-1:0]   drain_q, drain_d;
  logic               frame_done_q, frame_done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               cfg_ok, accept, legal, last_pix;

  assign cfg_ok = (cfg_width >= DIM_W'(3)) && (cfg_height >= DIM_W'(3)) &&
                  ((cfg_stride == 2'd1) || (cfg_stride == 2'd2));

  assign pix_ready = ~rst & (state_q == S_RUN) & win_ready;
  assign accept    = pix_ready & pix_valid;
  assign seg_wr_en = accept;
  assign seg_pixel = accept ? pix_in : '0;
  assign seg_rst   = rst | (state_q == S_CLR);
  assign win_valid = ~rst & tag_q[SEG_LAT-1] & seg_data_valid;
  assign win_row   = orow_q;
  assign win_col   = ocol_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;

  // Stride 2 only needs even (r-2),(c-2), i.e. even r and c.
  assign legal    = (r_q >= DIM_W'(2)) && (c_q >= DIM_W'(2)) &&
                    (~s2_q || (~r_q[0] && ~c_q[0]));
  assign last_pix = (r_q == h_q - DIM_W'(1)) && (c_q == w_q - DIM_W'(1));

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d      = state_q;
    w_d          = w_q;
    h_d          = h_q;
    ow_d         = ow_q;
    s2_d         = s2_q;
    r_d          = r_q;
    c_d          = c_q;
    orow_d       = orow_q;
    ocol_d       = ocol_q;
    drain_d      = drain_q;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;

    tag_d[0] = accept & legal;
    for (int i = 1; i < SEG_LAT; i++) tag_d[i] = tag_q[i-1];

    if (win_valid) begin
      if (ocol_q == ow_q - DIM_W'(1)) begin
        ocol_d = '0;
        orow_d = orow_q + DIM_W'(1);
      end else begin
        ocol_d = ocol_q + DIM_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            w_d     = cfg_width;
            h_d     = cfg_height;
            s2_d    = (cfg_stride == 2'd2);
            ow_d    = (cfg_stride == 2'd2) ? ((cfg_width - DIM_W'(3)) >> 1) + DIM_W'(1)
                                           : cfg_width - DIM_W'(2);
            state_d = S_CLR;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_CLR: begin
        r_d     = '0;
        c_d     = '0;
        orow_d  = '0;
        ocol_d  = '0;
        tag_d   = '0;
        drain_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (accept) begin
          if (c_q == w_q - DIM_W'(1)) begin
            c_d = '0;
            r_d = r_q + DIM_W'(1);
          end else begin
            c_d = c_q + DIM_W'(1);
          end
          if (last_pix) begin
            drain_d = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // The last tagged window leaves the delay line during the final drain cycle.
        if (drain_q == CNT_W'(SEG_LAT - 1)) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          drain_d = drain_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      w_q          <= '0;
      h_q          <= '0;
      ow_q         <= '0;
      s2_q         <= 1'b0;
      r_q          <= '0;
      c_q          <= '0;
      orow_q       <= '0;
      ocol_q       <= '0;
      tag_q        <= '0;
      drain_q      <= '0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      h_q          <= h_d;
      ow_q         <= ow_d;
      s2_q         <= s2_d;
      r_q          <= r_d;
      c_q          <= c_d;
      orow_q       <= orow_d;
      ocol_q       <= ocol_d;
      tag_q        <= tag_d;
      drain_q      <= drain_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl; a one-cycle data_valid stand-in models fifo_segment.
module tb_window_scan_ctrl;
  localparam int DATA_W  = 14;
  localparam int DIM_W   = 8;
  localparam int SEG_LAT = 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic [DIM_W-1:0]         cfg_width = '0;
  logic [DIM_W-1:0]         cfg_height = '0;
  logic [1:0]               cfg_stride = '0;
  logic signed [DATA_W-1:0] pix_in = '0;
  logic                     pix_valid = 1'b0;
  logic                     pix_ready;
  logic                     win_ready = 1'b1;
  logic                     seg_rst;
  logic                     seg_wr_en;
  logic signed [DATA_W-1:0] seg_pixel;
  logic                     seg_dv_q = 1'b0;
  logic                     win_valid;
  logic [DIM_W-1:0]         win_row, win_col;
  logic                     busy, frame_done, cfg_err;

  window_scan_ctrl #(.DATA_W(DATA_W), .DIM_W(DIM_W), .SEG_LAT(SEG_LAT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_stride(cfg_stride),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .win_ready(win_ready), .seg_rst(seg_rst), .seg_wr_en(seg_wr_en),
    .seg_pixel(seg_pixel), .seg_data_valid(seg_dv_q), .win_valid(win_valid),
    .win_row(win_row), .win_col(win_col), .busy(busy),
    .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Segment output is valid one cycle after each write, cleared by seg_rst.
  always @(posedge clk) seg_dv_q <= seg_rst ? 1'b0 : seg_wr_en;

  int cyc = 0;
  int win_rc[$];
  int win_pix[$];
  int win_cyc[$];
  int fd_cnt = 0;
  int low_wins = 0;
  int acc13_cyc = -1;
  int prev_pix = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (win_valid) begin
      win_rc.push_back(int'(win_row) * 256 + int'(win_col));
      win_pix.push_back(prev_pix);
      win_cyc.push_back(cyc);
      if (!win_ready) low_wins <= low_wins + 1;
    end
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (seg_wr_en && seg_pixel == 14'sd13) acc13_cyc <= cyc;
    prev_pix <= seg_wr_en ? int'(seg_pixel) : -1;
  end

  int  checks = 0;
  int  failures = 0;
  bit  clr_seg_rst, clr_busy, feed_timeout, done_timeout;
  int  low_cycles, ready_while_low;

  task automatic start_frame(input int w, input int h, input int s);
    @(posedge clk); #1;
    cfg_width = DIM_W'(w); cfg_height = DIM_W'(h); cfg_stride = 2'(s); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    clr_seg_rst = seg_rst;
    clr_busy    = busy;
    @(posedge clk); #1;
  endtask

  // Offers pixels from+1..to in raster order; optional valid toggling and a 3-cycle win_ready drop.
  task automatic feed(input int from, input int to, input bit toggle, input int stall_at);
    int idx = from;
    int guard = 0;
    int left = 0;
    bit acc;
    bit stalled = 1'b0;
    low_cycles = 0;
    ready_while_low = 0;
    pix_valid = 1'b1;
    pix_in = DATA_W'(from + 1);
    win_ready = 1'b1;
    while (idx < to && guard < 2000) begin
      @(negedge clk);
      acc = pix_valid && pix_ready;
      if (!win_ready) begin
        low_cycles++;
        if (pix_ready) ready_while_low++;
      end
      @(posedge clk); #1;
      guard++;
      if (acc) idx++;
      if (left > 0) left--;
      else if (!stalled && idx == stall_at) begin
        stalled = 1'b1;
        left = 3;
      end
      win_ready = (left == 0);
      pix_valid = (idx < to) && (toggle ? !pix_valid : 1'b1);
      pix_in = DATA_W'(idx + 1);
    end
    pix_valid = 1'b0;
    win_ready = 1'b1;
    feed_timeout = (idx < to);
  endtask

  task automatic wait_done();
    int k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    done_timeout = busy;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    pix_valid = 1'b1; pix_in = 14'sd5; win_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL reset_pix_ready got=%b exp=0", pix_ready); end
    checks++; if (seg_wr_en !== 1'b0) begin failures++; $display("FAIL reset_seg_wr_en got=%b exp=0", seg_wr_en); end
    checks++; if (seg_pixel !== '0) begin failures++; $display("FAIL reset_seg_pixel got=%0d exp=0", seg_pixel); end
    checks++; if (seg_rst !== 1'b1) begin failures++; $display("FAIL reset_seg_rst got=%b exp=1", seg_rst); end
    checks++; if ({win_valid, busy, frame_done, cfg_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {win_valid, busy, frame_done, cfg_err}); end
    checks++; if ({win_row, win_col} !== '0) begin failures++; $display("FAIL reset_coords got=%0d,%0d exp=0,0", win_row, win_col); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({seg_rst, busy, seg_wr_en} !== 3'b0) begin failures++; $display("FAIL idle_after_reset got=%b exp=000", {seg_rst, busy, seg_wr_en}); end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic test_stride1();
    int wb = win_rc.size();
    int fb = fd_cnt;
    int exp_pix[9] = '{13, 14, 15, 18, 19, 20, 23, 24, 25};
    start_frame(5, 5, 1);
    checks++; if ({clr_seg_rst, clr_busy} !== 2'b11) begin failures++; $display("FAIL s1_clr got=%b exp=11", {clr_seg_rst, clr_busy}); end
    feed(0, 25, 1'b0, -1);
    wait_done();
    checks++; if ({feed_timeout, done_timeout} !== 2'b00) begin failures++; $display("FAIL s1_timeout got=%b exp=00", {feed_timeout, done_timeout}); end
    checks++; if (win_rc.size() - wb !== 9) begin failures++; $display("FAIL s1_count got=%0d exp=9", win_rc.size() - wb); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (win_rc[wb+i] !== (i / 3) * 256 + i % 3 || win_pix[wb+i] !== exp_pix[i]) begin
        failures++;
        $display("FAIL s1_win%0d got rc=%0d pix=%0d exp rc=%0d pix=%0d", i, win_rc[wb+i], win_pix[wb+i], (i / 3) * 256 + i % 3, exp_pix[i]);
      end
    end
    checks++; if (win_cyc[wb] !== acc13_cyc + SEG_LAT) begin failures++; $display("FAIL s1_latency got=%0d exp=%0d", win_cyc[wb], acc13_cyc + SEG_LAT); end
    checks++; if (fd_cnt - fb !== 1) begin failures++; $display("FAIL s1_frame_done got=%0d exp=1", fd_cnt - fb); end
  endtask

  task automatic test_stride2();
    int wb = win_rc.size();
    int fb = fd_cnt;
    int exp_pix[4] = '{13, 15, 23, 25};
    start_frame(5, 5, 2);
    feed(0, 25, 1'b0, -1);
    wait_done();
    checks++; if ({feed_timeout, done_timeout} !== 2'b00) begin failures++; $display("FAIL s2_timeout got=%b exp=00", {feed_timeout, done_timeout}); end
    checks++; if (win_rc.size() - wb !== 4) begin failures++; $display("FAIL s2_count got=%0d exp=4", win_rc.size() - wb); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (win_rc[wb+i] !== (i / 2) * 256 + i % 2 || win_pix[wb+i] !== exp_pix[i]) begin
        failures++;
        $display("FAIL s2_win%0d got rc=%0d pix=%0d exp rc=%0d pix=%0d", i, win_rc[wb+i], win_pix[wb+i], (i / 2) * 256 + i % 2, exp_pix[i]);
      end
    end
    checks++; if (fd_cnt - fb !== 1) begin failures++; $display("FAIL s2_frame_done got=%0d exp=1", fd_cnt - fb); end
  endtask

  task automatic test_min_frame();
    int wb = win_rc.size();
    start_frame(3, 3, 2);
    feed(0, 9, 1'b0, -1);
    wait_done();
    checks++; if (win_rc.size() - wb !== 1) begin failures++; $display("FAIL min_count got=%0d exp=1", win_rc.size() - wb); end
    checks++; if (win_rc[wb] !== 0 || win_pix[wb] !== 9) begin failures++; $display("FAIL min_win got rc=%0d pix=%0d exp rc=0 pix=9", win_rc[wb], win_pix[wb]); end
  endtask

  task automatic test_backpressure();
    int wb = win_rc.size();
    int lb = low_wins;
    int exp_pix[8] = '{15, 16, 17, 18, 21, 22, 23, 24};
    start_frame(6, 4, 1);
    feed(0, 24, 1'b0, 16);
    wait_done();
    checks++; if ({feed_timeout, done_timeout} !== 2'b00) begin failures++; $display("FAIL bp_timeout got=%b exp=00", {feed_timeout, done_timeout}); end
    checks++; if (low_cycles !== 3 || ready_while_low !== 0) begin failures++; $display("FAIL bp_ready got low=%0d ready_hi=%0d exp low=3 ready_hi=0", low_cycles, ready_while_low); end
    checks++; if (low_wins - lb > SEG_LAT) begin failures++; $display("FAIL bp_inflight got=%0d exp<=%0d", low_wins - lb, SEG_LAT); end
    checks++; if (win_rc.size() - wb !== 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", win_rc.size() - wb); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (win_rc[wb+i] !== (i / 4) * 256 + i % 4 || win_pix[wb+i] !== exp_pix[i]) begin
        failures++;
        $display("FAIL bp_win%0d got rc=%0d pix=%0d exp rc=%0d pix=%0d", i, win_rc[wb+i], win_pix[wb+i], (i / 4) * 256 + i % 4, exp_pix[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int wb;
    int fb;
    start_frame(5, 5, 1);
    feed(0, 10, 1'b0, -1);
    rst = 1'b1; pix_valid = 1'b1; pix_in = 14'sd11;
    @(negedge clk);
    checks++; if ({seg_rst, pix_ready, seg_wr_en} !== 3'b100) begin failures++; $display("FAIL rst_mid_during got=%b exp=100", {seg_rst, pix_ready, seg_wr_en}); end
    @(posedge clk); #1;
    rst = 1'b0; pix_valid = 1'b0;
    @(negedge clk);
    checks++; if ({busy, win_valid} !== 2'b00) begin failures++; $display("FAIL rst_mid_after got=%b exp=00", {busy, win_valid}); end
    wb = win_rc.size();
    fb = fd_cnt;
    start_frame(5, 5, 1);
    feed(0, 25, 1'b0, -1);
    wait_done();
    checks++; if (win_rc.size() - wb !== 9) begin failures++; $display("FAIL rst_mid_count got=%0d exp=9", win_rc.size() - wb); end
    checks++; if (win_pix[wb] !== 13 || win_rc[wb+8] !== 2 * 256 + 2) begin failures++; $display("FAIL rst_mid_wins got first_pix=%0d last_rc=%0d exp 13 and 514", win_pix[wb], win_rc[wb+8]); end
    checks++; if (fd_cnt - fb !== 1) begin failures++; $display("FAIL rst_mid_frame_done got=%0d exp=1", fd_cnt - fb); end
  endtask

  task automatic test_cfg_err();
    int tw[3] = '{2, 5, 5};
    int th[3] = '{5, 2, 5};
    int ts[3] = '{1, 1, 3};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cfg_width = DIM_W'(tw[i]); cfg_height = DIM_W'(th[i]); cfg_stride = 2'(ts[i]); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checks++; if ({cfg_err, busy} !== 2'b10) begin failures++; $display("FAIL cfg_err%0d got=%b exp=10", i, {cfg_err, busy}); end
      @(negedge clk);
      checks++; if ({cfg_err, busy} !== 2'b00) begin failures++; $display("FAIL cfg_err%0d_pulse got=%b exp=00", i, {cfg_err, busy}); end
    end
  endtask

  task automatic test_start_busy();
    int wb = win_rc.size();
    int fb = fd_cnt;
    int exp_pix[9] = '{13, 14, 15, 18, 19, 20, 23, 24, 25};
    start_frame(5, 5, 1);
    feed(0, 12, 1'b0, -1);
    cfg_width = 8'd3; cfg_height = 8'd3; cfg_stride = 2'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++; if ({cfg_err, busy} !== 2'b01) begin failures++; $display("FAIL busy_start got=%b exp=01", {cfg_err, busy}); end
    @(posedge clk); #1;
    feed(12, 25, 1'b0, -1);
    wait_done();
    checks++; if (win_rc.size() - wb !== 9) begin failures++; $display("FAIL busy_count got=%0d exp=9", win_rc.size() - wb); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (win_pix[wb+i] !== exp_pix[i]) begin failures++; $display("FAIL busy_win%0d got pix=%0d exp=%0d", i, win_pix[wb+i], exp_pix[i]); end
    end
    checks++; if (fd_cnt - fb !== 1) begin failures++; $display("FAIL busy_frame_done got=%0d exp=1", fd_cnt - fb); end
  endtask

  task automatic test_toggle_valid();
    int wb = win_rc.size();
    int fb = fd_cnt;
    int exp_pix[9] = '{13, 14, 15, 18, 19, 20, 23, 24, 25};
    start_frame(5, 5, 1);
    feed(0, 25, 1'b1, -1);
    wait_done();
    checks++; if ({feed_timeout, done_timeout} !== 2'b00) begin failures++; $display("FAIL tog_timeout got=%b exp=00", {feed_timeout, done_timeout}); end
    checks++; if (win_rc.size() - wb !== 9) begin failures++; $display("FAIL tog_count got=%0d exp=9", win_rc.size() - wb); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (win_rc[wb+i] !== (i / 3) * 256 + i % 3 || win_pix[wb+i] !== exp_pix[i]) begin
        failures++;
        $display("FAIL tog_win%0d got rc=%0d pix=%0d exp rc=%0d pix=%0d", i, win_rc[wb+i], win_pix[wb+i], (i / 3) * 256 + i % 3, exp_pix[i]);
      end
    end
    checks++; if (fd_cnt - fb !== 1) begin failures++; $display("FAIL tog_frame_done got=%0d exp=1", fd_cnt - fb); end
  endtask

  initial begin
    test_reset();
    test_stride1();
    test_stride2();
    test_min_frame();
    test_backpressure();
    test_reset_midframe();
    test_cfg_err();
    test_start_busy();
    test_toggle_valid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
